// File: rtl/led_breathe_pwm.sv
// Breathing LED driver: a step-timed duty ramp (up, hold, down, hold) feeding a
// free-running PWM, with enable, resync and status outputs for a debug bank.
module led_breathe_pwm #(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 390625,
  parameter int HOLD_STEPS  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                sync_in,
  output logic                led,
  output logic [PWM_BITS-1:0] duty,
  output logic [2:0]          phase,
  output logic                cycle_done
);

  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [PWM_BITS-1:0] MAX_M1    = PWM_BITS'((2 ** PWM_BITS) - 2);
  localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);
  localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UP      = 3'd1,
    S_HOLD_HI = 3'd2,
    S_DOWN    = 3'd3,
    S_HOLD_LO = 3'd4
  } state_t;

  state_t              r_state, w_state_nx;
  logic [PWM_BITS-1:0] r_duty, w_duty_nx;
  logic [PWM_BITS-1:0] r_pwm, w_pwm_nx;
  logic [SW-1:0]       r_step, w_step_nx;
  logic [HW-1:0]       r_hold, w_hold_nx;
  logic                r_led, w_led_nx;
  logic                r_done, w_done_nx;
  logic                w_strobe;

  assign w_strobe = (r_state != S_IDLE) && (r_step == STEP_LAST);

  // NOTE: every next-state signal gets a default before any branch, so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nx = r_state;
    w_duty_nx  = r_duty;
    w_pwm_nx   = r_pwm;
    w_step_nx  = r_step;
    w_hold_nx  = r_hold;
    w_done_nx  = 1'b0;
    w_led_nx   = (r_pwm < r_duty);

    if (!en) begin
      w_state_nx = S_IDLE;
      w_duty_nx  = '0;
      w_pwm_nx   = '0;
      w_step_nx  = '0;
      w_hold_nx  = '0;
      w_led_nx   = 1'b0;
    end else if (sync_in || r_state == S_IDLE) begin
      // Restart at the bottom of the ramp; any coincident step is dropped.
      w_state_nx = S_UP;
      w_duty_nx  = '0;
      w_pwm_nx   = '0;
      w_step_nx  = '0;
      w_hold_nx  = '0;
    end else begin
      w_pwm_nx  = (r_pwm == MAX_M1) ? '0 : r_pwm + 1'b1;
      w_step_nx = w_strobe ? '0 : r_step + 1'b1;
      if (w_strobe) begin
        case (r_state)
          S_UP: begin
            w_duty_nx = r_duty + 1'b1;
            if (r_duty == MAX_M1) begin
              w_state_nx = S_HOLD_HI;
              w_hold_nx  = '0;
            end
          end
          S_HOLD_HI: begin
            if (r_hold == HOLD_LAST) begin
              w_state_nx = S_DOWN;
              w_hold_nx  = '0;
            end else begin
              w_hold_nx = r_hold + 1'b1;
            end
          end
          S_DOWN: begin
            w_duty_nx = r_duty - 1'b1;
            if (r_duty == DUTY_ONE) begin
              w_state_nx = S_HOLD_LO;
              w_hold_nx  = '0;
            end
          end
          S_HOLD_LO: begin
            if (r_hold == HOLD_LAST) begin
              w_state_nx = S_UP;
              w_hold_nx  = '0;
              w_done_nx  = 1'b1;
            end else begin
              w_hold_nx = r_hold + 1'b1;
            end
          end
          default: w_state_nx = S_IDLE;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // pre-edge values, and the reset branch is asynchronous on rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_duty  <= '0;
      r_pwm   <= '0;
      r_step  <= '0;
      r_hold  <= '0;
      r_led   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_duty  <= w_duty_nx;
      r_pwm   <= w_pwm_nx;
      r_step  <= w_step_nx;
      r_hold  <= w_hold_nx;
      r_led   <= w_led_nx;
      r_done  <= w_done_nx;
    end
  end

  assign led        = r_led;
  assign duty       = r_duty;
  assign phase      = r_state;
  assign cycle_done = r_done;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Bench for led_breathe_pwm: a time-since-restart model predicts every output of
// a fast instance each cycle; a slow-step instance pins PWM high-time per duty.
module tb_led_breathe_pwm;

  localparam int MAXV = 7;
  localparam int SC   = 4;
  localparam int H    = 2;
  localparam int PER  = 2 * MAXV + 2 * H;
  localparam int PCLK = PER * SC;

  logic       clk = 1'b0;
  logic       rst_n, en, sync_in, en_s;
  logic       led, cycle_done, led_s, done_s;
  logic [2:0] duty, phase, duty_s, phase_s;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  led_breathe_pwm #(.PWM_BITS(3), .STEP_CYCLES(SC), .HOLD_STEPS(H)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_in(sync_in),
    .led(led), .duty(duty), .phase(phase), .cycle_done(cycle_done)
  );

  led_breathe_pwm #(.PWM_BITS(3), .STEP_CYCLES(1000), .HOLD_STEPS(H)) u_slow (
    .clk(clk), .rst_n(rst_n), .en(en_s), .sync_in(1'b0),
    .led(led_s), .duty(duty_s), .phase(phase_s), .cycle_done(done_s)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: the pattern is a pure function of t, clocks since the last restart.
  function automatic int pos_of(input int t);
    return (t / SC) % PER;
  endfunction

  function automatic int duty_of(input int t);
    int p = pos_of(t);
    if (p < MAXV) return p;
    if (p < MAXV + H) return MAXV;
    if (p < 2 * MAXV + H) return MAXV - (p - MAXV - H);
    return 0;
  endfunction

  function automatic int phase_of(input int t);
    int p = pos_of(t);
    if (p < MAXV) return 1;
    if (p < MAXV + H) return 2;
    if (p < 2 * MAXV + H) return 3;
    return 4;
  endfunction

  logic m_act, m_led, m_done;
  int   m_t;
  int   exp_duty, exp_phase;

  always_comb begin
    exp_duty  = m_act ? duty_of(m_t) : 0;
    exp_phase = m_act ? phase_of(m_t) : 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act  <= 1'b0;
      m_t    <= 0;
      m_led  <= 1'b0;
      m_done <= 1'b0;
    end else begin
      m_led <= en && ((m_t % MAXV) < exp_duty);
      if (!en) begin
        m_act  <= 1'b0;
        m_t    <= 0;
        m_done <= 1'b0;
      end else if (sync_in || !m_act) begin
        m_act  <= 1'b1;
        m_t    <= 0;
        m_done <= 1'b0;
      end else begin
        m_t    <= m_t + 1;
        m_done <= ((m_t + 1) % PCLK) == 0;
      end
    end
  end

  always @(negedge clk) begin
    check("led", int'(led), int'(m_led));
    check("duty", int'(duty), exp_duty);
    check("phase", int'(phase), exp_phase);
    check("cycle_done", int'(cycle_done), int'(m_done));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_model(input int ph, input int du, input string name);
    int n = 0;
    while (!(exp_phase == ph && exp_duty == du) && n < 400) begin
      cyc();
      n++;
    end
    check(name, int'(n < 400), 1);
  endtask

  initial begin
    int n, cnt;
    rst_n = 1'b0; en = 1'b0; sync_in = 1'b0; en_s = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_led", int'(led), 0);
    check("rst_duty", int'(duty), 0);
    check("rst_phase", int'(phase), 0);
    check("rst_done", int'(cycle_done), 0);
    rst_n = 1'b1;
    repeat (50) cyc();
    check("idle_phase", int'(phase), 0);

    // Full pattern: first cycle_done 72 clocks after entering UP, then once per period.
    en = 1'b1;
    cyc();
    check("up_entry_phase", int'(phase), 1);
    check("up_entry_duty", int'(duty), 0);
    n = 0;
    while (!cycle_done && n < 200) begin
      cyc();
      n++;
    end
    check("first_period_clks", n, 72);
    cnt = 0;
    repeat (72) begin
      cyc();
      cnt += int'(cycle_done);
    end
    check("pulses_per_period", cnt, 1);

    // Resync in DOWN at duty 5.
    wait_model(3, 5, "reach_down5");
    sync_in = 1'b1;
    cyc();
    sync_in = 1'b0;
    check("resync_phase", int'(phase), 1);
    check("resync_duty", int'(duty), 0);
    n = 0;
    while (duty != 3'd1 && n < 20) begin
      cyc();
      n++;
    end
    check("resync_first_step_clks", n, 4);

    // Disable during UP at duty 4, then re-enable.
    wait_model(1, 4, "reach_up4");
    en = 1'b0;
    cyc();
    check("dis_phase", int'(phase), 0);
    check("dis_duty", int'(duty), 0);
    check("dis_led", int'(led), 0);
    repeat (5) cyc();
    en = 1'b1;
    cyc();
    check("reen_phase", int'(phase), 1);
    check("reen_duty", int'(duty), 0);

    // Sync coincident with the last HOLD_LO step: no cycle_done.
    n = 0;
    while (!(m_act && ((m_t + 1) % PCLK) == 0) && n < 400) begin
      cyc();
      n++;
    end
    check("reach_last_hold_lo", int'(n < 400), 1);
    check("last_hold_lo_phase", int'(phase), 4);
    sync_in = 1'b1;
    cyc();
    sync_in = 1'b0;
    check("sync_vs_done_done", int'(cycle_done), 0);
    check("sync_vs_done_phase", int'(phase), 1);

    // Async reset mid HOLD_HI, away from any clock edge.
    wait_model(2, 7, "reach_hold_hi");
    #1;
    rst_n = 1'b0;
    #1;
    check("async_led", int'(led), 0);
    check("async_duty", int'(duty), 0);
    check("async_phase", int'(phase), 0);
    check("async_done", int'(cycle_done), 0);
    cyc();
    cyc();
    rst_n = 1'b1;

    // Randomized enable/resync traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) en = ~en;
      sync_in = ($urandom_range(59) == 0);
      cyc();
    end
    sync_in = 1'b0;
    en = 1'b0;
    cyc();

    // Slow-step instance: PWM high-time at duty 3, 7 and 0.
    en_s = 1'b1;
    cyc();
    n = 0;
    while (duty_s != 3'd3 && n < 5000) begin
      cyc();
      n++;
    end
    check("slow_reach_duty3_clks", n, 3000);
    repeat (10) cyc();
    cnt = 0;
    repeat (7) begin
      cyc();
      cnt += int'(led_s);
    end
    check("pwm_duty3_high", cnt, 3);
    n = 0;
    while (duty_s != 3'd7 && n < 5000) begin
      cyc();
      n++;
    end
    check("slow_reach_duty7", int'(n < 5000), 1);
    repeat (10) cyc();
    cnt = 0;
    repeat (14) begin
      cyc();
      cnt += int'(led_s);
    end
    check("pwm_duty7_high", cnt, 14);
    n = 0;
    while (phase_s != 3'd4 && n < 20000) begin
      cyc();
      n++;
    end
    check("slow_reach_hold_lo", int'(n < 20000), 1);
    repeat (10) cyc();
    cnt = 0;
    repeat (14) begin
      cyc();
      cnt += int'(led_s);
    end
    check("pwm_duty0_high", cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/led_breathe_pwm.md
Name: led_breathe_pwm

Overview:
- Downstream LED driver stage: replaces a plain toggle output with a "breathing" LED.
- Duty ramps up, holds, ramps down, holds, and repeats, driving a single LED pin through a free-running PWM.
- Self-timed from the system clock; enable and resync inputs come from board control logic.
- Also exports the current duty and phase for a status/debug LED bank.

Parameters:
- PWM_BITS, 8, duty/PWM counter width; MAX = 2^PWM_BITS-1.
- STEP_CYCLES, 390625, clk cycles per duty step (100 MHz -> about 1 s per ramp at 8 bits); legal range >= 1.
- HOLD_STEPS, 64, steps spent at each extreme (full on / full off); legal range >= 1.

Ports:
- clk  in  1  system clock, 100 MHz nominal.
- rst_n  in  1  asynchronous reset, active-low.
- en  in  1  pattern enable; 0 forces LED off and idle.
- sync_in  in  1  one-cycle pulse; restarts the pattern at the start of the ramp-up.
- led  out  1  PWM LED drive, registered.
- duty  out  PWM_BITS  current duty value.
- phase  out  3  FSM state: 0 IDLE, 1 UP, 2 HOLD_HI, 3 DOWN, 4 HOLD_LO.
- cycle_done  out  1  one-cycle pulse at the end of each full breathe period.

Behaviour:
- Reset (rst_n=0, async): led=0, duty=0, phase=IDLE, cycle_done=0; pwm_cnt, step_cnt and hold_cnt all =0.
- PWM counter:
  - pwm_cnt counts 0..MAX-1, wraps to 0, giving a period of MAX cycles.
  - Runs whenever phase != IDLE.
  - led(t+1) = (pwm_cnt(t) < duty(t)).
  - duty=0 gives led constantly 0; duty=MAX gives led constantly 1.
- Step prescaler:
  - step_cnt counts 0..STEP_CYCLES-1 when phase != IDLE.
  - step strobe is asserted on the cycle step_cnt==STEP_CYCLES-1; step_cnt wraps to 0 on that cycle.
- FSM, with all updates on a step strobe unless noted:
  - IDLE: duty=0, led=0, all counters held at 0. If en=1, go to UP on the next cycle with duty=0.
  - UP: duty+=1. On the step where duty becomes MAX, go to HOLD_HI with hold_cnt=0.
  - HOLD_HI: hold_cnt+=1. On the step where hold_cnt==HOLD_STEPS-1, go to DOWN with hold_cnt=0.
  - DOWN: duty-=1. On the step where duty becomes 0, go to HOLD_LO with hold_cnt=0.
  - HOLD_LO: hold_cnt+=1. On the step where hold_cnt==HOLD_STEPS-1, go to UP and pulse cycle_done for exactly 1 cycle.
- Arithmetic: duty never wraps. It saturates at MAX in UP and at 0 in DOWN by construction, via the transitions above.
- Period: one full breathe = (2*MAX + 2*HOLD_STEPS) steps = that many * STEP_CYCLES clocks.
- Priority, highest first: rst_n > en=0 > sync_in > step strobe.
- en deassert: on the next edge phase=IDLE, duty=0, led=0, counters=0, cycle_done=0, from any state.
- sync_in with en=1: on the next edge phase=UP, duty=0, step_cnt=0, hold_cnt=0, pwm_cnt=0.
  - Any coincident step strobe is discarded.
  - cycle_done is not pulsed.
- sync_in with en=0: ignored.
- Simultaneous sync_in and the last HOLD_LO step: sync wins, and cycle_done is not asserted.
- Reset mid-ramp: immediate return to the reset values; resumes from IDLE after release.

Test Plan:
Bench parameters: PWM_BITS=3 (MAX=7), STEP_CYCLES=4, HOLD_STEPS=2.
- Reset/idle: hold rst_n=0, then release with en=0 for 50 cycles -> led=0, duty=0, phase=0, cycle_done=0 throughout.
- Full pattern: set en=1 -> phase 1 at next edge; duty goes 0,1..7 with one step every 4 clks. Then HOLD_HI for 8 clks, duty 7..0, HOLD_LO for 8 clks. cycle_done pulses once, 72 clks per period; the first pulse occurs 72 clks after entering UP.
- PWM duty check: freeze the DUT at duty=3 via a long-STEP_CYCLES build (1000) -> led high for exactly 3 of every 7 clks. At duty=7, led is constantly 1; at duty=0, led is constantly 0.
- Resync: pulse sync_in during DOWN at duty=5 -> next edge phase=1, duty=0, step_cnt=0. Next increment to duty=1 occurs exactly 4 clks later; no cycle_done.
- Disable mid-ramp: drop en during UP at duty=4 -> next edge phase=0, duty=0, led=0. Re-enable -> restarts from duty=0.
- Async reset: assert rst_n=0 mid-HOLD_HI, off a clock edge -> all outputs 0 immediately, without waiting for clk.
